// File: rtl/wb_memtest_pkg.sv
// Shared types and constants for the Wishbone memory-test engine.
//   state_t   : sequencer states
//   mode_t    : pattern selection codes
//   LFSR_POLY : Galois tap mask for x^32+x^22+x^2+x+1 (right-shifting form)
package wb_memtest_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_GAP,
      ST_RD_REQ,
      ST_RD_GAP,
      ST_FIN
   } state_t;

   typedef enum logic [1:0] {
      MODE_CONST = 2'd0,
      MODE_ADDR  = 2'd1,
      MODE_LFSR  = 2'd2,
      MODE_NADDR = 2'd3
   } mode_t;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/wb_memtest_pattern.sv
// Pattern generator for the memory-test engine.
//   wb_clk_i, wb_rstn_i : clock, async active-low reset
//   load                : reload LFSR from seed (zero seed becomes 1)
//   advance             : step LFSR once (one word)
//   seed, mode          : pattern configuration
//   adr                 : address of the word being generated
//   word                : pattern word for the state after the coming clock edge
module wb_memtest_pattern
   import wb_memtest_pkg::*;
(
   input  logic        wb_clk_i,
   input  logic        wb_rstn_i,
   input  logic        load,
   input  logic        advance,
   input  logic [31:0] seed,
   input  mode_t       mode,
   input  logic [31:0] adr,
   output logic [31:0] word
);

   logic [31:0] lfsr_q;
   logic [31:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = (seed == 32'h0) ? 32'h1 : seed;
      end else if (advance) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         lfsr_q <= 32'h0;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // Built from next-state values so the top can register the word
   // and present it in the same cycle the request starts.
   always_comb begin
      word = seed;
      case (mode)
         MODE_CONST: word = seed;
         MODE_ADDR:  word = adr;
         MODE_LFSR:  word = lfsr_d;
         MODE_NADDR: word = ~adr;
         default:    word = seed;
      endcase
   end

endmodule

// File: rtl/wb_hyperram_memtest.sv
// Wishbone classic memory-test initiator: writes a pattern to count_i words
// from base_adr_i, reads them back and compares.
//   wb_clk_i, wb_rstn_i        : clock, async active-low reset
//   start_i, base_adr_i, count_i, mode_i, seed_i : test launch and configuration
//   wbm_*                      : Wishbone classic initiator port
//   busy_o, done_o, pass_o     : run status
//   err_cnt_o, first_err_adr_o, timeout_o : result details
//
// state     | meaning
// ST_IDLE   | waiting for start_i
// ST_WR_REQ | write request on the bus, waiting for ack
// ST_WR_GAP | one idle bus cycle between writes
// ST_RD_REQ | read request on the bus, compare on ack
// ST_RD_GAP | one idle bus cycle between reads
// ST_FIN    | done_o pulse, results final
module wb_hyperram_memtest
   import wb_memtest_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             wb_clk_i,
   input  logic             wb_rstn_i,
   input  logic             start_i,
   input  logic [31:0]      base_adr_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic [1:0]       mode_i,
   input  logic [31:0]      seed_i,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic [31:0]      wbm_dat_i,
   input  logic             wbm_ack_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [31:0]      first_err_adr_o,
   output logic             timeout_o
);

   localparam int TO_W = 16;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [31:0]      base_q, base_d, adr_q, adr_d, seed_q, seed_d;
   logic [31:0]      ferr_q, ferr_d, pat_q, pat_next;
   logic [CNT_W-1:0] count_q, count_d, rem_q, rem_d, err_q, err_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic             tmo_q, tmo_d, pass_q, pass_d;
   logic             pat_load, pat_adv, req_next;
   logic             cyc_q, we_q, busy_q, done_q;
   logic [3:0]       sel_q;

   wb_memtest_pattern u_pattern (
      .wb_clk_i  (wb_clk_i),
      .wb_rstn_i (wb_rstn_i),
      .load      (pat_load),
      .advance   (pat_adv),
      .seed      (seed_d),
      .mode      (mode_d),
      .adr       (adr_d),
      .word      (pat_next)
   );

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      base_d   = base_q;
      adr_d    = adr_q;
      seed_d   = seed_q;
      ferr_d   = ferr_q;
      count_d  = count_q;
      rem_d    = rem_q;
      err_d    = err_q;
      to_d     = to_q;
      tmo_d    = tmo_q;
      pass_d   = pass_q;
      pat_load = 1'b0;
      pat_adv  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               base_d   = base_adr_i & 32'hFFFF_FFFC;
               adr_d    = base_adr_i & 32'hFFFF_FFFC;
               mode_d   = mode_t'(mode_i);
               seed_d   = seed_i;
               count_d  = count_i;
               rem_d    = count_i;
               err_d    = '0;
               ferr_d   = 32'h0;
               tmo_d    = 1'b0;
               pass_d   = 1'b0;
               to_d     = '0;
               pat_load = 1'b1;
               state_d  = (count_i == '0) ? ST_FIN : ST_WR_REQ;
            end
         end
         ST_WR_REQ: begin
            if (wbm_ack_i) begin
               state_d = ST_WR_GAP;
            end else if (to_q == TO_LAST) begin
               tmo_d   = 1'b1;
               state_d = ST_FIN;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         ST_WR_GAP: begin
            to_d = '0;
            if (rem_q == CNT_W'(1)) begin
               rem_d    = count_q;
               adr_d    = base_q;
               pat_load = 1'b1;
               state_d  = ST_RD_REQ;
            end else begin
               rem_d   = rem_q - 1'b1;
               adr_d   = adr_q + 32'd4;
               pat_adv = 1'b1;
               state_d = ST_WR_REQ;
            end
         end
         ST_RD_REQ: begin
            if (wbm_ack_i) begin
               state_d = ST_RD_GAP;
               if (wbm_dat_i != pat_q) begin
                  if (err_q != '1) begin
                     err_d = err_q + 1'b1;
                  end
                  if (err_q == '0) begin
                     ferr_d = adr_q;
                  end
               end
            end else if (to_q == TO_LAST) begin
               tmo_d   = 1'b1;
               state_d = ST_FIN;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         ST_RD_GAP: begin
            to_d = '0;
            if (rem_q == CNT_W'(1)) begin
               state_d = ST_FIN;
            end else begin
               rem_d   = rem_q - 1'b1;
               adr_d   = adr_q + 32'd4;
               pat_adv = 1'b1;
               state_d = ST_RD_REQ;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if ((state_d == ST_FIN) && (state_q != ST_FIN)) begin
         pass_d = (err_d == '0) && !tmo_d;
      end
   end

   assign req_next = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_CONST;
         base_q  <= 32'h0;
         adr_q   <= 32'h0;
         seed_q  <= 32'h0;
         ferr_q  <= 32'h0;
         pat_q   <= 32'h0;
         count_q <= '0;
         rem_q   <= '0;
         err_q   <= '0;
         to_q    <= '0;
         tmo_q   <= 1'b0;
         pass_q  <= 1'b0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= 4'h0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         base_q  <= base_d;
         adr_q   <= adr_d;
         seed_q  <= seed_d;
         ferr_q  <= ferr_d;
         pat_q   <= pat_next;
         count_q <= count_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
         to_q    <= to_d;
         tmo_q   <= tmo_d;
         pass_q  <= pass_d;
         cyc_q   <= req_next;
         we_q    <= (state_d == ST_WR_REQ);
         sel_q   <= {4{req_next}};
         busy_q  <= (state_d == ST_WR_REQ) || (state_d == ST_WR_GAP) ||
                    (state_d == ST_RD_REQ) || (state_d == ST_RD_GAP);
         done_q  <= (state_d == ST_FIN);
      end
   end

   assign wbm_cyc_o       = cyc_q;
   assign wbm_stb_o       = cyc_q;
   assign wbm_we_o        = we_q;
   assign wbm_sel_o       = sel_q;
   assign wbm_adr_o       = adr_q;
   assign wbm_dat_o       = pat_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign pass_o          = pass_q;
   assign err_cnt_o       = err_q;
   assign first_err_adr_o = ferr_q;
   assign timeout_o       = tmo_q;

endmodule
